// File: rtl/i2s_pkg.sv
// Shared definitions for the i2s sample scheduler: default sample width,
// scheduler FSM states and transmitter timing constants.
package i2s_pkg;

  localparam int I2S_BPS          = 24;
  // Transmitter latches the sample this many cycles after its ready pulse
  localparam int READY_TO_LOAD    = 5;
  localparam int SAMPLE_SETUP_MAX = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    STREAM,
    STOP
  } state_e;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Small synchronous sample FIFO with registered full flag and occupancy count.
// Head data is presented combinationally from the read pointer.
module i2s_sample_fifo #(
  parameter int BPS   = 24,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [BPS-1:0] wdata,
  output logic [BPS-1:0] rdata,
  output logic [LW-1:0]  level,
  output logic           full,
  output logic           empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [BPS-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           full_q, full_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    full_d   = (level_d == DEPTH_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // Storage is data only; pointers define validity so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = full_q;
  assign empty = (level_q == '0);

endmodule

// File: rtl/i2s_sample_scheduler.sv
// Arbitrates two sample producers into a FIFO and feeds the i2s transmitter,
// answering each ready pulse with the next sample or silence on underrun.
module i2s_sample_scheduler
  import i2s_pkg::*;
#(
  parameter int BPS         = I2S_BPS,
  parameter int FIFO_DEPTH  = 4,
  parameter int START_LEVEL = 2
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic                          in_start,
  input  logic                          in_stop,
  input  logic                          in_req0_valid,
  input  logic [BPS-1:0]                in_req0_sample,
  output logic                          out_req0_ready,
  input  logic                          in_req1_valid,
  input  logic [BPS-1:0]                in_req1_sample,
  output logic                          out_req1_ready,
  input  logic                          in_i2s_ready,
  output logic [BPS-1:0]                out_i2s_sample,
  output logic                          out_i2s_en,
  output logic [$clog2(FIFO_DEPTH):0]   out_level,
  output logic                          out_busy,
  output logic                          out_underrun
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] START_L = LW'(START_LEVEL);

  state_e         state_q, state_d;
  logic           en_q, en_d;
  logic [BPS-1:0] sample_q, sample_d;
  logic           underrun_q, underrun_d;
  logic           last_grant_q, last_grant_d;
  logic           ready_prev_q;
  logic           stop_cnt_q, stop_cnt_d;

  logic           gnt0, gnt1, push0, push1, push, pop, rise;
  logic [BPS-1:0] fifo_wdata, fifo_rdata;
  logic [LW-1:0]  fifo_level;
  logic           fifo_full, fifo_empty;

  i2s_sample_fifo #(
    .BPS   (BPS),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk   (in_clk),
    .rst   (in_rst),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Tie goes to the producer that did not win the previous push
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!fifo_full) begin
      if (in_req0_valid && in_req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else if (in_req0_valid) begin
        gnt0 = 1'b1;
      end else if (in_req1_valid) begin
        gnt1 = 1'b1;
      end
    end
    push0        = in_req0_valid && gnt0;
    push1        = in_req1_valid && gnt1;
    push         = push0 || push1;
    fifo_wdata   = push1 ? in_req1_sample : in_req0_sample;
    last_grant_d = push ? push1 : last_grant_q;
  end

  assign rise = in_i2s_ready && !ready_prev_q;

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    sample_d   = sample_q;
    underrun_d = underrun_q;
    stop_cnt_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (in_start && !in_stop) begin
          underrun_d = 1'b0;
          state_d    = ARM;
        end
      end
      ARM: begin
        if (in_stop) begin
          state_d = IDLE;
        end else if (fifo_level >= START_L && in_i2s_ready) begin
          pop      = 1'b1;
          sample_d = fifo_rdata;
          en_d     = 1'b1;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        // A stop arriving with a rise still delivers that sample slot
        if (rise) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            sample_d = fifo_rdata;
          end else begin
            sample_d   = '0;
            underrun_d = 1'b1;
          end
        end
        if (in_stop) begin
          en_d    = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        en_d = 1'b0;
        if (in_i2s_ready) begin
          stop_cnt_d = 1'b1;
          if (stop_cnt_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= IDLE;
      en_q         <= 1'b0;
      sample_q     <= '0;
      underrun_q   <= 1'b0;
      last_grant_q <= 1'b1;
      ready_prev_q <= 1'b0;
      stop_cnt_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      sample_q     <= sample_d;
      underrun_q   <= underrun_d;
      last_grant_q <= last_grant_d;
      ready_prev_q <= in_i2s_ready;
      stop_cnt_q   <= stop_cnt_d;
    end
  end

  assign out_req0_ready = gnt0;
  assign out_req1_ready = gnt1;
  assign out_i2s_sample = sample_q;
  assign out_i2s_en     = en_q;
  assign out_level      = fifo_level;
  assign out_busy       = (state_q != IDLE);
  assign out_underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Directed bench for i2s_sample_scheduler: arbitration, start, ready pulses,
// underrun, stop handshake and mid-stream reset.
module tb_i2s_sample_scheduler;

  localparam int BPS = 24;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic           v0 = 1'b0;
  logic [BPS-1:0] s0 = '0;
  logic           r0;
  logic           v1 = 1'b0;
  logic [BPS-1:0] s1 = '0;
  logic           r1;
  logic           i2s_ready = 1'b0;
  logic [BPS-1:0] i2s_sample;
  logic           i2s_en;
  logic [2:0]     level;
  logic           busy;
  logic           underrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2s_sample_scheduler #(
    .BPS         (BPS),
    .FIFO_DEPTH  (4),
    .START_LEVEL (2)
  ) dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .in_start       (start),
    .in_stop        (stop),
    .in_req0_valid  (v0),
    .in_req0_sample (s0),
    .out_req0_ready (r0),
    .in_req1_valid  (v1),
    .in_req1_sample (s1),
    .out_req1_ready (r1),
    .in_i2s_ready   (i2s_ready),
    .out_i2s_sample (i2s_sample),
    .out_i2s_en     (i2s_en),
    .out_level      (level),
    .out_busy       (busy),
    .out_underrun   (underrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_en", 32'(i2s_en), 32'd0);
    chk("rst_sample", 32'(i2s_sample), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Tie arbitration: 0,1,0,1 then full
    v0 = 1'b1; s0 = 24'h111111;
    v1 = 1'b1; s1 = 24'h222222;
    #1;
    chk("tie1_r0", 32'(r0), 32'd1);
    chk("tie1_r1", 32'(r1), 32'd0);
    tick();
    chk("tie2_r0", 32'(r0), 32'd0);
    chk("tie2_r1", 32'(r1), 32'd1);
    tick();
    chk("tie3_r0", 32'(r0), 32'd1);
    chk("tie3_r1", 32'(r1), 32'd0);
    tick();
    chk("tie4_r0", 32'(r0), 32'd0);
    chk("tie4_r1", 32'(r1), 32'd1);
    tick();
    chk("full_level", 32'(level), 32'd4);
    chk("full_r0", 32'(r0), 32'd0);
    chk("full_r1", 32'(r1), 32'd0);
    v0 = 1'b0; v1 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("flush_level", 32'(level), 32'd0);

    // Preload two samples from producer 0
    v0 = 1'b1; s0 = 24'hABCDEF;
    tick();
    s0 = 24'h123456;
    tick();
    v0 = 1'b0;
    chk("preload_level", 32'(level), 32'd2);

    // Start with transmitter idle
    start = 1'b1; i2s_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_en", 32'(i2s_en), 32'd0);
    tick();
    chk("start_en", 32'(i2s_en), 32'd1);
    chk("start_sample", 32'(i2s_sample), 32'hABCDEF);
    chk("start_level", 32'(level), 32'd1);
    i2s_ready = 1'b0;
    tick(); tick();
    chk("stream_hold", 32'(i2s_sample), 32'hABCDEF);

    // Ready pulse: next sample within 2 cycles, stable through +5
    i2s_ready = 1'b1;
    tick();
    i2s_ready = 1'b0;
    chk("pulse_sample", 32'(i2s_sample), 32'h123456);
    chk("pulse_level", 32'(level), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("pulse_stable", 32'(i2s_sample), 32'h123456);
    end

    // Underrun on empty FIFO
    i2s_ready = 1'b1;
    tick();
    i2s_ready = 1'b0;
    chk("ur_sample", 32'(i2s_sample), 32'h000000);
    chk("ur_flag", 32'(underrun), 32'd1);
    tick(); tick();
    chk("ur_sticky", 32'(underrun), 32'd1);
    chk("ur_en", 32'(i2s_en), 32'd1);

    // Single producer 1 request is granted
    v1 = 1'b1; s1 = 24'h0F0F0F;
    #1;
    chk("single_r1", 32'(r1), 32'd1);
    chk("single_r0", 32'(r0), 32'd0);
    tick();
    v1 = 1'b0;
    chk("single_level", 32'(level), 32'd1);
    i2s_ready = 1'b1;
    tick();
    i2s_ready = 1'b0;
    chk("p1_sample", 32'(i2s_sample), 32'h0F0F0F);
    chk("p1_ur_sticky", 32'(underrun), 32'd1);

    // Stop, then transmitter idle handshake
    v0 = 1'b1; s0 = 24'h555555;
    tick();
    v0 = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_en", 32'(i2s_en), 32'd0);
    chk("stop_busy", 32'(busy), 32'd1);
    chk("stop_sample_hold", 32'(i2s_sample), 32'h0F0F0F);
    i2s_ready = 1'b1;
    tick();
    chk("stop_wait_busy", 32'(busy), 32'd1);
    tick();
    i2s_ready = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_level", 32'(level), 32'd1);

    // in_start clears underrun; restart streams the retained head
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_ur", 32'(underrun), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    v0 = 1'b1; s0 = 24'h666666;
    tick();
    s0 = 24'h777777;
    tick();
    v0 = 1'b0;
    chk("restart_level", 32'(level), 32'd3);
    i2s_ready = 1'b1;
    tick();
    i2s_ready = 1'b0;
    chk("restart_en", 32'(i2s_en), 32'd1);
    chk("restart_sample", 32'(i2s_sample), 32'h555555);
    v0 = 1'b1; s0 = 24'h888888;
    tick();
    v0 = 1'b0;
    chk("mid_level", 32'(level), 32'd3);

    // Reset in STREAM
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_en", 32'(i2s_en), 32'd0);
    chk("mrst_level", 32'(level), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ur", 32'(underrun), 32'd0);
    chk("mrst_sample", 32'(i2s_sample), 32'd0);

    // Start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_sample_scheduler.md
Name: i2s_sample_scheduler

Overview:
- Sits between two sample producers and the i2s transmitter.
- Arbitrates producer writes into a small sample FIFO and starts/stops the transmitter via its in_en.
- Answers each transmitter ready pulse with the next FIFO sample before the transmitter's load point.
- Inserts silence (zero) on underrun and reports it.

Parameters:
- BPS, 24, sample width in bits; must match the transmitter.
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.
- START_LEVEL, 2, FIFO occupancy required before streaming starts; 1..FIFO_DEPTH.

Ports:
- in_clk  input  1  system clock, 73.728 MHz
- in_rst  input  1  synchronous, active-high reset
- in_start  input  1  one-cycle request to begin streaming
- in_stop  input  1  one-cycle request to stop streaming
- in_req0_valid  input  1  producer 0 has a sample
- in_req0_sample  input  BPS  producer 0 sample
- out_req0_ready  output  1  producer 0 sample accepted this cycle
- in_req1_valid  input  1  producer 1 has a sample
- in_req1_sample  input  BPS  producer 1 sample
- out_req1_ready  output  1  producer 1 sample accepted this cycle
- in_i2s_ready  input  1  transmitter out_ready
- out_i2s_sample  output  BPS  to transmitter sample, registered
- out_i2s_en  output  1  to transmitter in_en, registered
- out_level  output  clog2(FIFO_DEPTH)+1  FIFO occupancy
- out_busy  output  1  state != IDLE
- out_underrun  output  1  sticky; cleared by in_rst or in_start

Behaviour:
- Reset values: out_i2s_en=0, out_i2s_sample=0, out_level=0, out_underrun=0, out_busy=0, FIFO empty, last_grant=1 (producer 0 wins the first tie).
- Arbitration (combinational ready):
  - At most one push per cycle, only when the registered full flag is 0.
  - One valid: that producer is granted.
  - Both valid: grant the producer opposite last_grant; last_grant updates on every push.
  - out_reqN_ready=1 only for the granted producer; a push occurs when valid&&ready.
- FIFO:
  - Push and pop may occur in the same cycle; level is unchanged.
  - A push while full is impossible because ready is gated on the registered full flag, including when a pop happens the same cycle.
  - Pop when empty never occurs.
- Ready rising edge (rise): in_i2s_ready=1 && previous-cycle in_i2s_ready=0.
- FSM states:
  - IDLE: en=0. in_start clears out_underrun and goes to ARM.
  - ARM: en=0. When level>=START_LEVEL and in_i2s_ready=1 (transmitter idle), pop the head into out_i2s_sample and set en=1 on the same edge, then go to STREAM. in_stop returns to IDLE.
  - STREAM: en=1. On rise, the next cycle pops the head into out_i2s_sample, or loads 0 and sets out_underrun if empty. out_i2s_sample must be stable within 2 cycles of the rise; the transmitter latches 5 cycles after the rise. in_stop goes to STOP.
  - STOP: en=0; out_i2s_sample holds. Once in_i2s_ready has been 1 for 2 consecutive cycles (transmitter back in IDLE; its pulse is 1 cycle), go to IDLE. FIFO contents are retained.
- Simultaneous events:
  - in_start and in_stop together: in_stop wins.
  - in_stop and rise together in STREAM: the pop or silence is still performed, then go to STOP.
- Reset mid-stream: en drops next cycle, FIFO flushed. The transmitter self-idles at its next ask because en=0.
- Ignored inputs: in_start outside IDLE; in_stop in IDLE or STOP.

Decomposition:
- Shared package i2s_pkg holds:
  - BPS default
  - FSM state typedef {IDLE, ARM, STREAM, STOP}
  - localparam READY_TO_LOAD=5, the transmitter's ask-to-load latency
  - localparam SAMPLE_SETUP_MAX=2
- One sub-module: i2s_sample_fifo (synchronous FIFO; push, pop, data, level, full, empty).

Test Plan:
- Tie arbitration: both producers valid, FIFO empty, depth 4 → accept order src0,src1,src0,src1, then both readys 0 at level=4.
- Start: preload 0xABCDEF and 0x123456, in_start, i2s_ready=1 → en=1 with sample=0xABCDEF on the same edge, level=1.
- Ready pulse: 1-cycle in_i2s_ready → out_i2s_sample=0x123456 within 2 cycles and stable through +5, level=0.
- Underrun: pulse with FIFO empty → sample=0x000000, out_underrun=1 and held; the next in_start clears it.
- Stop: in_stop → en=0 next cycle; ready held high 2 cycles → out_busy=0, FIFO level unchanged.
- Mid-stream reset: in_rst in STREAM with level=3 → next cycle en=0, level=0, out_busy=0, underrun=0.
